bsg_mask_coalesce: RTL

Byte-masked write coalescer that sits directly upstream of the team's bitwise mux. It accepts a stream of partial writes, each a data word plus a byte mask, over a ready/valid handshake. It merges them into one accumulated word and mask, then presents the merged word with a bit-expanded select vector: `data_o` drives the mux `data1_i` and `sel_o` drives the mux `sel_i`. This lets a downstream stage patch only the written bits into an existing word.

---
 rtl/bsg_mask_coalesce_pkg.sv | 12 +
 rtl/bsg_expand_bitmask.sv | 14 +
 rtl/bsg_mux_bitwise.sv | 13 +
 rtl/bsg_mask_coalesce.sv | 114 +++++++++++
 4 files changed

// File: rtl/bsg_mask_coalesce_pkg.sv
// Shared types and constants for the byte-masked write coalescer.
package bsg_mask_coalesce_pkg;

    localparam int byte_width_lp = 8;

    typedef enum logic [1:0] {
        e_empty = 2'd0,
        e_accum = 2'd1,
        e_full  = 2'd2
    } coalesce_state_e;

endpackage

// File: rtl/bsg_expand_bitmask.sv
// Replicates each input bit expand_p times (mask bit k -> output bits [k*expand_p +: expand_p]).
module bsg_expand_bitmask #(
    parameter int in_width_p = 1,
    parameter int expand_p   = 1
) (
    input  logic [in_width_p-1:0]          i,
    output logic [in_width_p*expand_p-1:0] o
);

    for (genvar k = 0; k < in_width_p; k++) begin : g_rep
        assign o[k*expand_p +: expand_p] = {expand_p{i[k]}};
    end

endmodule

// File: rtl/bsg_mux_bitwise.sv
// Bitwise 2:1 mux: each output bit takes data1_i where sel_i is set, else data0_i.
module bsg_mux_bitwise #(
    parameter int width_p = 1
) (
    input  logic [width_p-1:0] data0_i,
    input  logic [width_p-1:0] data1_i,
    input  logic [width_p-1:0] sel_i,
    output logic [width_p-1:0] data_o
);

    assign data_o = (data0_i & ~sel_i) | (data1_i & sel_i);

endmodule

// File: rtl/bsg_mask_coalesce.sv
// Merges masked partial writes into one word plus a bit-expanded select for the
// downstream bitwise mux. The word is held in FULL until the consumer yumis it.
module bsg_mask_coalesce
    import bsg_mask_coalesce_pkg::*;
#(
    parameter int width_p     = 128,
    parameter int max_beats_p = 4,
    localparam int mask_width_lp  = width_p / byte_width_lp,
    localparam int beats_width_lp = $clog2(max_beats_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic                      v_i,
    input  logic [width_p-1:0]        data_i,
    input  logic [mask_width_lp-1:0]  mask_i,
    input  logic                      last_i,
    output logic                      ready_and_o,

    output logic                      v_o,
    output logic [width_p-1:0]        data_o,
    output logic [width_p-1:0]        sel_o,
    output logic [mask_width_lp-1:0]  mask_o,
    output logic [beats_width_lp-1:0] beats_o,
    input  logic                      yumi_i
);

    coalesce_state_e            state_r;
    logic [width_p-1:0]         acc_data_r;
    logic [mask_width_lp-1:0]   acc_mask_r;
    logic [beats_width_lp-1:0]  beats_r;

    logic                       accept;
    logic                       take;
    logic                       close;
    logic [width_p-1:0]         base_data;
    logic [mask_width_lp-1:0]   base_mask;
    logic [beats_width_lp-1:0]  base_beats;
    logic [width_p-1:0]         beat_sel;
    logic [width_p-1:0]         merged_data;
    logic [mask_width_lp-1:0]   merged_mask;
    logic [beats_width_lp-1:0]  merged_beats;

    assign ready_and_o = ~reset_i & (state_r != e_full);
    assign accept      = v_i & ready_and_o;
    assign take        = yumi_i & (state_r == e_full);

    // EMPTY starts from a blank word so unwritten bytes read back as zero.
    assign base_data  = (state_r == e_accum) ? acc_data_r : '0;
    assign base_mask  = (state_r == e_accum) ? acc_mask_r : '0;
    assign base_beats = (state_r == e_accum) ? beats_r    : '0;

    bsg_expand_bitmask #(
        .in_width_p (mask_width_lp),
        .expand_p   (byte_width_lp)
    ) beat_expand (
        .i (mask_i),
        .o (beat_sel)
    );

    bsg_mux_bitwise #(
        .width_p (width_p)
    ) merge_mux (
        .data0_i (base_data),
        .data1_i (data_i),
        .sel_i   (beat_sel),
        .data_o  (merged_data)
    );

    assign merged_mask  = base_mask | mask_i;
    assign merged_beats = base_beats + beats_width_lp'(1);

    // Close conditions look at post-update values.
    assign close = last_i
                 | (merged_beats == beats_width_lp'(max_beats_p))
                 | (&merged_mask);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r    <= e_empty;
            acc_data_r <= '0;
            acc_mask_r <= '0;
            beats_r    <= '0;
        end else if (accept) begin
            state_r    <= close ? e_full : e_accum;
            acc_data_r <= merged_data;
            acc_mask_r <= merged_mask;
            beats_r    <= merged_beats;
        end else if (take) begin
            state_r    <= e_empty;
            acc_data_r <= '0;
            acc_mask_r <= '0;
            beats_r    <= '0;
        end
    end

    bsg_expand_bitmask #(
        .in_width_p (mask_width_lp),
        .expand_p   (byte_width_lp)
    ) sel_expand (
        .i (acc_mask_r),
        .o (sel_o)
    );

    assign v_o     = (state_r == e_full);
    assign data_o  = acc_data_r;
    assign mask_o  = acc_mask_r;
    assign beats_o = beats_r;

    yumi_only_when_valid: assert property (
        @(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o
    );

endmodule
